fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_pkg.sv | 14 +
 rtl/if_id_reg.sv | 53 +++++
 rtl/fetch_stage.sv | 106 ++++++++++
 tb/tb_fetch_stage.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    // Fetch control state; RUN fetches, HALTED parks the PC on the HLT word.
    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    localparam logic [15:0] RESET_PC_DEFAULT    = 16'h0000;
    localparam logic [3:0]  HALT_OPCODE_DEFAULT = 4'hF;
    localparam logic [15:0] PC_INC              = 16'd2;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: instruction, its PC+2 and a valid bit.
// Priority: reset > bubble > load > hold. A bubble clears only the valid bit
// so the last real instruction word stays visible for debug.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [15:0] instr_i,
    input  logic [15:0] pc_plus2_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        valid_o
);

    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_plus2_q, pc_plus2_d;
    logic        valid_q, valid_d;

    // Next-state selection for the load / bubble / hold controls.
    always_comb begin
        instr_d    = instr_q;
        pc_plus2_d = pc_plus2_q;
        valid_d    = valid_q;
        if (bubble_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d    = instr_i;
            pc_plus2_d = pc_plus2_i;
            valid_d    = 1'b1;
        end
    end

    // Register update with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            instr_q    <= 16'h0000;
            pc_plus2_q <= 16'h0000;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus2_q <= pc_plus2_d;
            valid_q    <= valid_d;
        end
    end

    assign instr_o    = instr_q;
    assign pc_plus2_o = pc_plus2_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED control and IF/ID register.
//
// Control semantics (one place): each cycle the highest-priority condition
// wins -- reset > redirect > stall > normal. redirect loads the (even-aligned)
// target and inserts a bubble regardless of stall or state. stall freezes PC
// and IF/ID. A normal cycle in RUN reads imem at pc and latches the word
// into IF/ID; an HLT opcode is latched but parks the PC and enters HALTED.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter logic [3:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         stall,
    input  logic         redirect,
    input  logic [15:0]  redirect_pc,
    output logic [15:0]  imem_addr,
    output logic         imem_rd_en,
    input  logic [15:0]  imem_data,
    output logic [15:0]  pc,
    output logic [15:0]  if_instr,
    output logic [15:0]  if_pc_plus2,
    output logic         if_valid,
    output logic         fetch_halted,
    output fetch_state_e state_dbg_o
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  pc_plus2;
    logic         is_halt;
    logic         load;
    logic         bubble;
    logic         rd_en;
    logic         unused_redirect_lsb;

    assign pc_plus2            = pc_q + PC_INC;
    assign is_halt             = (imem_data[15:12] == HALT_OPCODE);
    assign unused_redirect_lsb = redirect_pc[0];

    // Next-state, next-PC and IF/ID control decode.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        bubble  = 1'b0;
        rd_en   = 1'b0;
        if (redirect) begin
            pc_d    = {redirect_pc[15:1], 1'b0};
            bubble  = 1'b1;
            state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (!stall) begin
                        rd_en = 1'b1;
                        load  = 1'b1;
                        if (is_halt) begin
                            state_d = HALTED;
                        end else begin
                            pc_d = pc_plus2;
                        end
                    end
                end
                HALTED: begin
                    if (!stall) begin
                        bubble = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // PC and state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    if_id_reg u_if_id (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .bubble_i   (bubble),
        .instr_i    (imem_data),
        .pc_plus2_i (pc_plus2),
        .instr_o    (if_instr),
        .pc_plus2_o (if_pc_plus2),
        .valid_o    (if_valid)
    );

    assign pc           = pc_q;
    assign imem_addr    = pc_q;
    assign imem_rd_en   = rd_en;
    assign fetch_halted = (state_q == HALTED);
    assign state_dbg_o  = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage with an external instruction memory model.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic         clk;
    logic         rst_n;
    logic         stall;
    logic         redirect;
    logic [15:0]  redirect_pc;
    logic [15:0]  imem_addr;
    logic         imem_rd_en;
    logic [15:0]  imem_data;
    logic [15:0]  pc;
    logic [15:0]  if_instr;
    logic [15:0]  if_pc_plus2;
    logic         if_valid;
    logic         fetch_halted;
    fetch_state_e state_dbg;

    logic [15:0] mem [0:32767];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        rd_en;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] pp2;
        logic        valid;
        logic        halted;
    } vec_t;

    vec_t vecs[$];
    logic [32:0] exp_q[$];

    fetch_stage #(
        .RESET_PC    (16'h0000),
        .HALT_OPCODE (4'hF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_addr    (imem_addr),
        .imem_rd_en   (imem_rd_en),
        .imem_data    (imem_data),
        .pc           (pc),
        .if_instr     (if_instr),
        .if_pc_plus2  (if_pc_plus2),
        .if_valid     (if_valid),
        .fetch_halted (fetch_halted),
        .state_dbg_o  (state_dbg)
    );

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction memory, combinational read
    assign imem_data = mem[imem_addr[15:1]];

    task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic s, input logic rd,
                                input logic [15:0] rpc, input logic en,
                                input logic [15:0] p, input logic [15:0] ins,
                                input logic [15:0] pp2, input logic v, input logic h);
        vec_t t;
        t.rst_n = r; t.stall = s; t.redirect = rd; t.rpc = rpc; t.rd_en = en;
        t.pc = p; t.instr = ins; t.pp2 = pp2; t.valid = v; t.halted = h;
        return t;
    endfunction

    // Drive one cycle of inputs, check read enable before the edge and
    // registered outputs just after it.
    task automatic run_vec(input vec_t v, input string tag);
        rst_n       = v.rst_n;
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        #1;
        chk({tag, ".rd_en"}, {32'd0, imem_rd_en}, {32'd0, v.rd_en});
        @(posedge clk);
        #1;
        chk({tag, ".pc"},     {17'd0, pc},          {17'd0, v.pc});
        chk({tag, ".addr"},   {17'd0, imem_addr},   {17'd0, v.pc});
        chk({tag, ".instr"},  {17'd0, if_instr},    {17'd0, v.instr});
        chk({tag, ".pp2"},    {17'd0, if_pc_plus2}, {17'd0, v.pp2});
        chk({tag, ".valid"},  {32'd0, if_valid},    {32'd0, v.valid});
        chk({tag, ".halted"}, {32'd0, fetch_halted}, {32'd0, v.halted});
    endtask

    initial begin
        logic [15:0] mpc;
        logic [32:0] last;
        logic [32:0] e;
        logic        st;

        rst_n = 1'b0; stall = 1'b1; redirect = 1'b1; redirect_pc = 16'h0041;
        for (int i = 0; i < 32768; i++) mem[i] = {4'h1, i[11:0]};
        mem[16'h0000 >> 1] = 16'h1234;
        mem[16'h0002 >> 1] = 16'h2345;
        mem[16'h0004 >> 1] = 16'h3456;
        mem[16'h0006 >> 1] = 16'h4567;
        mem[16'h0008 >> 1] = 16'h5678;
        mem[16'h0010 >> 1] = 16'hF000;
        mem[16'h0020 >> 1] = 16'h2020;
        mem[16'h0022 >> 1] = 16'h2222;
        mem[16'h0040 >> 1] = 16'h4040;
        mem[16'hFFFE >> 1] = 16'h7FFE;

        // Reset (with redirect and stall asserted), streaming, stall, redirect,
        // halt, redirect-over-HLT and PC wrap.
        vecs.push_back(mk(0,1,1,16'h0041, 0, 16'h0000,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(0,1,1,16'h0041, 0, 16'h0000,16'h0000,16'h0000,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0002,16'h1234,16'h0002,1,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0004,16'h2345,16'h0004,1,0));
        vecs.push_back(mk(1,1,0,16'h0000, 0, 16'h0004,16'h2345,16'h0004,1,0));
        vecs.push_back(mk(1,1,0,16'h0000, 0, 16'h0004,16'h2345,16'h0004,1,0));
        vecs.push_back(mk(1,1,0,16'h0000, 0, 16'h0004,16'h2345,16'h0004,1,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0006,16'h3456,16'h0006,1,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0008,16'h4567,16'h0008,1,0));
        vecs.push_back(mk(1,1,1,16'h0041, 0, 16'h0040,16'h4567,16'h0008,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0042,16'h4040,16'h0042,1,0));
        vecs.push_back(mk(1,0,1,16'h0010, 0, 16'h0010,16'h4040,16'h0042,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0010,16'hF000,16'h0012,1,1));
        vecs.push_back(mk(1,1,0,16'h0000, 0, 16'h0010,16'hF000,16'h0012,1,1));
        vecs.push_back(mk(1,0,0,16'h0000, 0, 16'h0010,16'hF000,16'h0012,0,1));
        vecs.push_back(mk(1,0,0,16'h0000, 0, 16'h0010,16'hF000,16'h0012,0,1));
        vecs.push_back(mk(1,0,1,16'h0020, 0, 16'h0020,16'hF000,16'h0012,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0022,16'h2020,16'h0022,1,0));
        vecs.push_back(mk(1,0,1,16'h0010, 0, 16'h0010,16'h2020,16'h0022,0,0));
        vecs.push_back(mk(1,0,1,16'h0021, 0, 16'h0020,16'h2020,16'h0022,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0022,16'h2020,16'h0022,1,0));
        vecs.push_back(mk(1,0,1,16'hFFFF, 0, 16'hFFFE,16'h2020,16'h0022,0,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0000,16'h7FFE,16'h0000,1,0));
        vecs.push_back(mk(1,0,0,16'h0000, 1, 16'h0002,16'h1234,16'h0002,1,0));

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while HALTED, with redirect and stall also asserted.
        run_vec(mk(1,0,1,16'h0010, 0, 16'h0010,16'h1234,16'h0002,0,0), "hr_redir");
        run_vec(mk(1,0,0,16'h0000, 1, 16'h0010,16'hF000,16'h0012,1,1), "hr_hlt");
        chk("hr_state", {32'd0, state_dbg}, {32'd0, HALTED});
        run_vec(mk(1,0,0,16'h0000, 0, 16'h0010,16'hF000,16'h0012,0,1), "hr_park");
        run_vec(mk(0,1,1,16'h0040, 0, 16'h0000,16'h0000,16'h0000,0,0), "hr_reset");
        chk("hr_state_rst", {32'd0, state_dbg}, {32'd0, RUN});
        run_vec(mk(1,0,0,16'h0000, 1, 16'h0002,16'h1234,16'h0002,1,0), "hr_first");

        // Scoreboarded stream from 0x0200 with random stalls.
        run_vec(mk(1,0,1,16'h0200, 0, 16'h0200,16'h1234,16'h0002,0,0), "sb_redir");
        mpc  = 16'h0200;
        last = {1'b0, 16'h1234, 16'h0002};
        for (int c = 0; c < 60; c++) begin
            st = ($urandom_range(0, 3) == 0);
            rst_n = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; stall = st;
            if (!st) begin
                exp_q.push_back({1'b1, mem[mpc[15:1]], mpc + 16'd2});
                mpc = mpc + 16'd2;
            end
            #1;
            chk("sb_rd_en", {32'd0, imem_rd_en}, {32'd0, ~st});
            @(posedge clk);
            #1;
            if (!st) begin
                e    = exp_q.pop_front();
                last = e;
            end
            chk("sb_ifid", {if_valid, if_instr, if_pc_plus2}, last);
            chk("sb_pc", {17'd0, pc}, {17'd0, mpc});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
